// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the register-file write port, with a busy scoreboard
// for multi-cycle destinations. Optional forwarding ports under `WB_FWD_EN.
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s0_valid,
    input  logic [4:0]  s0_rd,
    input  logic [31:0] s0_data,
    output logic        s0_ready,
    input  logic        s1_valid,
    input  logic [4:0]  s1_rd,
    input  logic [31:0] s1_data,
    output logic        s1_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    output logic        iss_ready,
    output logic [31:0] busy_vec,
`ifdef WB_FWD_EN
    input  logic [4:0]  fwd_rs1,
    input  logic [4:0]  fwd_rs2,
    output logic        fwd_hit1,
    output logic        fwd_hit2,
    output logic [31:0] fwd_data1,
    output logic [31:0] fwd_data2,
`endif
    output logic        W_en,
    output logic [4:0]  Rd,
    output logic [31:0] Wr_data
);

    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0]  r_starve_cnt;
    logic [31:0] r_busy;
    logic        r_wen;
    logic [4:0]  r_rd;
    logic [31:0] r_wdata;

    logic        w_s1_win;
    logic        w_s0_xfer;
    logic        w_s1_xfer;
    logic        w_iss_set;
    logic [4:0]  w_win_rd;
    logic [31:0] w_win_data;
    logic [31:0] w_busy_nxt;

    // src0 has priority unless src1 has waited STARVE_MAX cycles
    assign w_s1_win  = s1_valid & (~s0_valid | (r_starve_cnt == LP_STARVE_MAX));
    assign s1_ready  = rst_n & w_s1_win;
    assign s0_ready  = rst_n & ~w_s1_win;
    assign w_s0_xfer = s0_valid & s0_ready;
    assign w_s1_xfer = s1_valid & s1_ready;

    assign iss_ready = ~r_busy[iss_rd];
    assign w_iss_set = iss_valid & iss_ready & (iss_rd != 5'd0);

    always_comb begin
        w_win_rd   = s0_rd;
        w_win_data = s0_data;
        if (w_s1_xfer) begin
            w_win_rd   = s1_rd;
            w_win_data = s1_data;
        end
    end

    // Clear applied before set so a same-cycle issue to the retiring rd stays busy
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_s1_xfer) begin
            w_busy_nxt[s1_rd] = 1'b0;
        end
        if (w_iss_set) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!s1_valid || w_s1_xfer) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != LP_STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wen   <= 1'b0;
            r_rd    <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= (w_s0_xfer | w_s1_xfer) & (w_win_rd != 5'd0);
            if (w_s0_xfer || w_s1_xfer) begin
                r_rd    <= w_win_rd;
                r_wdata <= w_win_data;
            end
        end
    end

    assign busy_vec = r_busy;
    assign W_en     = r_wen;
    assign Rd       = r_rd;
    assign Wr_data  = r_wdata;

`ifdef WB_FWD_EN
    // Covers reads that sample before the register file commits on the negedge
    assign fwd_hit1  = r_wen & (r_rd == fwd_rs1) & (fwd_rs1 != 5'd0);
    assign fwd_hit2  = r_wen & (r_rd == fwd_rs2) & (fwd_rs2 != 5'd0);
    assign fwd_data1 = r_wdata;
    assign fwd_data2 = r_wdata;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (STARVE_MAX=4);
// forwarding checks are compiled when WB_FWD_EN is defined.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s0_valid, s1_valid, iss_valid;
    logic [4:0]  s0_rd, s1_rd, iss_rd;
    logic [31:0] s0_data, s1_data;
    logic        s0_ready, s1_ready, iss_ready;
    logic [31:0] busy_vec;
    logic        W_en;
    logic [4:0]  Rd;
    logic [31:0] Wr_data;
`ifdef WB_FWD_EN
    logic [4:0]  fwd_rs1, fwd_rs2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s0_valid  (s0_valid),
        .s0_rd     (s0_rd),
        .s0_data   (s0_data),
        .s0_ready  (s0_ready),
        .s1_valid  (s1_valid),
        .s1_rd     (s1_rd),
        .s1_data   (s1_data),
        .s1_ready  (s1_ready),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .busy_vec  (busy_vec),
`ifdef WB_FWD_EN
        .fwd_rs1   (fwd_rs1),
        .fwd_rs2   (fwd_rs2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
`endif
        .W_en      (W_en),
        .Rd        (Rd),
        .Wr_data   (Wr_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        s0_valid  = 1'b1; s0_rd = 5'd4; s0_data = 32'h1111_1111;
        s1_valid  = 1'b1; s1_rd = 5'd6; s1_data = 32'h2222_2222;
        iss_valid = 1'b0; iss_rd = 5'd0;
`ifdef WB_FWD_EN
        fwd_rs1 = 5'd0; fwd_rs2 = 5'd0;
`endif

        // reset held two cycles with both sources requesting
        tick();
        tick();
        chk("rst_wen",    {31'd0, W_en}, 32'd0);
        chk("rst_rd",     {27'd0, Rd}, 32'd0);
        chk("rst_wdata",  Wr_data, 32'd0);
        chk("rst_busy",   busy_vec, 32'd0);
        chk("rst_s0rdy",  {31'd0, s0_ready}, 32'd0);
        chk("rst_s1rdy",  {31'd0, s1_ready}, 32'd0);

        // s0 alone
        rst_n = 1'b1;
        s1_valid = 1'b0;
        s0_rd = 5'd5; s0_data = 32'hDEAD_BEEF;
        #1;
        chk("s0only_s0rdy", {31'd0, s0_ready}, 32'd1);
        chk("s0only_s1rdy", {31'd0, s1_ready}, 32'd0);
        tick();
        chk("s0only_wen",   {31'd0, W_en}, 32'd1);
        chk("s0only_rd",    {27'd0, Rd}, 32'd5);
        chk("s0only_wdata", Wr_data, 32'hDEAD_BEEF);

        // contention: s0 wins four cycles, then s1, then s0 again
        s0_rd = 5'd1;
        s1_valid = 1'b1; s1_rd = 5'd2; s1_data = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            s0_data = 32'h100 + 32'(i);
            #1;
            chk("starve_s0rdy", {31'd0, s0_ready}, 32'd1);
            chk("starve_s1rdy", {31'd0, s1_ready}, 32'd0);
            tick();
            chk("starve_rd",    {27'd0, Rd}, 32'd1);
            chk("starve_wdata", Wr_data, 32'h100 + 32'(i));
        end
        #1;
        chk("starve5_s1rdy", {31'd0, s1_ready}, 32'd1);
        chk("starve5_s0rdy", {31'd0, s0_ready}, 32'd0);
        tick();
        chk("starve5_wen",   {31'd0, W_en}, 32'd1);
        chk("starve5_rd",    {27'd0, Rd}, 32'd2);
        chk("starve5_wdata", Wr_data, 32'h0000_0200);
        chk("cnt_clr_s0rdy", {31'd0, s0_ready}, 32'd1);
        chk("cnt_clr_s1rdy", {31'd0, s1_ready}, 32'd0);
        s0_valid = 1'b0; s1_valid = 1'b0;

        // scoreboard set / clear / same-cycle set-wins
        iss_valid = 1'b1; iss_rd = 5'd7;
        #1;
        chk("iss7_rdy0", {31'd0, iss_ready}, 32'd1);
        tick();
        iss_valid = 1'b0;
        chk("iss7_busy", busy_vec, 32'h0000_0080);
        chk("iss7_rdy1", {31'd0, iss_ready}, 32'd0);
        s1_valid = 1'b1; s1_rd = 5'd7; s1_data = 32'h0000_0077;
        #1;
        chk("s1rd7_rdy", {31'd0, s1_ready}, 32'd1);
        tick();
        chk("s1rd7_busy",  busy_vec, 32'd0);
        chk("s1rd7_wen",   {31'd0, W_en}, 32'd1);
        chk("s1rd7_rd",    {27'd0, Rd}, 32'd7);
        chk("s1rd7_wdata", Wr_data, 32'h0000_0077);
        iss_valid = 1'b1; iss_rd = 5'd7;
        #1;
        chk("same7_issrdy", {31'd0, iss_ready}, 32'd1);
        tick();
        iss_valid = 1'b0; s1_valid = 1'b0;
        chk("same7_busy", busy_vec, 32'h0000_0080);

        // issue blocked while busy: ignored, then s1 clears
        iss_valid = 1'b1; iss_rd = 5'd7;
        s1_valid = 1'b1; s1_rd = 5'd7;
        #1;
        chk("blk7_issrdy", {31'd0, iss_ready}, 32'd0);
        tick();
        iss_valid = 1'b0; s1_valid = 1'b0;
        chk("blk7_busy", busy_vec, 32'd0);

        // rd=0: consumed, dropped; issue to rd=0 never marks busy
        s0_valid = 1'b1; s0_rd = 5'd0; s0_data = 32'h0000_1234;
        iss_valid = 1'b1; iss_rd = 5'd0;
        #1;
        chk("rd0_s0rdy", {31'd0, s0_ready}, 32'd1);
        tick();
        s0_valid = 1'b0; iss_valid = 1'b0;
        chk("rd0_wen",  {31'd0, W_en}, 32'd0);
        chk("rd0_busy", busy_vec, 32'd0);
        tick();
        chk("idle_wen", {31'd0, W_en}, 32'd0);

        // reset mid-operation drops busy bits and pending write
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        chk("pre_rst_busy", busy_vec, 32'h0000_0200);
        s0_valid = 1'b1; s0_rd = 5'd10; s1_valid = 1'b1; s1_rd = 5'd11;
        rst_n = 1'b0;
        #1;
        chk("midrst_s0rdy", {31'd0, s0_ready}, 32'd0);
        chk("midrst_s1rdy", {31'd0, s1_ready}, 32'd0);
        tick();
        chk("midrst_busy", busy_vec, 32'd0);
        chk("midrst_wen",  {31'd0, W_en}, 32'd0);
        rst_n = 1'b1; s1_valid = 1'b0;

`ifdef WB_FWD_EN
        s0_valid = 1'b1; s0_rd = 5'd3; s0_data = 32'hA5A5_A5A5;
        tick();
        s0_valid = 1'b0;
        fwd_rs1 = 5'd3; fwd_rs2 = 5'd0;
        #1;
        chk("fwd_hit1",  {31'd0, fwd_hit1}, 32'd1);
        chk("fwd_data1", fwd_data1, 32'hA5A5_A5A5);
        chk("fwd_hit2",  {31'd0, fwd_hit2}, 32'd0);
        fwd_rs2 = 5'd4;
        #1;
        chk("fwd_miss2", {31'd0, fwd_hit2}, 32'd0);
`endif

        s0_valid = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
